// File: rtl/uart_cmd_pkg.sv
// Shared types and constants for the UART command controller.
// Byte timeout feature is enabled with UART_CMD_BYTE_TIMEOUT_EN.
package uart_cmd_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        ACK     = 1'b1
    } state_t;

    localparam int CLK_PER_BIT        = 2604;
    localparam int CLK_PER_BYTE       = 10 * CLK_PER_BIT;
    localparam int DEFAULT_TMO_CYCLES = 2 * CLK_PER_BYTE;

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/uart_cmd_tmo.sv
// Inter-byte timer: clearable up-counter with a terminal-count flag.
// Instantiated only when UART_CMD_BYTE_TIMEOUT_EN is defined.
module uart_cmd_tmo
    import uart_cmd_pkg::*;
#(
    parameter int TMO_CYCLES = DEFAULT_TMO_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] LAST = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TW'(1);
        end
    end

    assign tc = en && (count == LAST);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Assembles NUM_BYTES UART bytes (MSB first) into a command word.
// Optional inter-byte timeout: define UART_CMD_BYTE_TIMEOUT_EN.
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter int NUM_BYTES  = 2,
    parameter int TMO_CYCLES = DEFAULT_TMO_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   clr_rx_rdy,
    input  logic                   clr_cmd_rdy,
    output logic [8*NUM_BYTES-1:0] cmd,
    output logic                   cmd_rdy,
    output logic                   ovr_err,
    output logic                   tmo_err
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = cnt_width(NUM_BYTES);
    localparam logic [CW-1:0] FULL = CW'(NUM_BYTES);

    state_t        state;
    logic [W-1:0]  asm_sr;
    logic [CW-1:0] byte_cnt;
    logic          done;
    logic          tmo_fire;

    assign clr_rx_rdy = (state == ACK);
    assign done = (state == ACK) && !rx_rdy && (byte_cnt == FULL);

`ifdef UART_CMD_BYTE_TIMEOUT_EN
    logic tmo_en;
    logic tmo_clr;
    logic tmo_tc;

    // A byte arriving in the terminal cycle takes priority over the timeout.
    assign tmo_en   = (state == COLLECT) && (byte_cnt != '0);
    assign tmo_fire = tmo_tc && !rx_rdy;
    assign tmo_clr  = !tmo_en || rx_rdy || tmo_fire;

    uart_cmd_tmo #(
        .TMO_CYCLES(TMO_CYCLES)
    ) u_tmo (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (tmo_clr),
        .en   (tmo_en),
        .tc   (tmo_tc)
    );
`else
    logic unused_tmo;

    assign tmo_fire   = 1'b0;
    assign unused_tmo = ^TMO_CYCLES;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= COLLECT;
            byte_cnt <= '0;
            asm_sr   <= '0;
            cmd      <= '0;
            cmd_rdy  <= 1'b0;
            ovr_err  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            ovr_err <= 1'b0;
            tmo_err <= tmo_fire;
            if (clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
            unique case (state)
                COLLECT: begin
                    if (rx_rdy) begin
                        asm_sr   <= {asm_sr[W-9:0], rx_data};
                        byte_cnt <= byte_cnt + CW'(1);
                        state    <= ACK;
                    end else if (tmo_fire) begin
                        asm_sr   <= '0;
                        byte_cnt <= '0;
                    end
                end
                ACK: begin
                    if (!rx_rdy) begin
                        state <= COLLECT;
                    end
                    // Set beats a same-cycle clear, which also suppresses overrun.
                    if (done) begin
                        cmd      <= asm_sr;
                        cmd_rdy  <= 1'b1;
                        byte_cnt <= '0;
                        ovr_err  <= cmd_rdy && !clr_cmd_rdy;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with a transaction-level reference model.
// Timeout checks follow UART_CMD_BYTE_TIMEOUT_EN.
module tb_uart_cmd_ctrl;

    localparam int NB  = 2;
    localparam int TMO = 100;
    localparam int W   = 8 * NB;
`ifdef UART_CMD_BYTE_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         rx_rdy = 1'b0;
    logic [7:0]   rx_data = 8'h00;
    logic         clr_cmd_rdy = 1'b0;
    logic         clr_rx_rdy;
    logic [W-1:0] cmd;
    logic         cmd_rdy;
    logic         ovr_err;
    logic         tmo_err;

    int vecs = 0;
    int errs = 0;
    int cyc = 0;
    int clr_rises = 0;
    int clr_hi = 0;
    int ovr_cnt = 0;
    int tmo_cnt = 0;
    logic clr_prev = 1'b0;

    bit           m_valid = 1'b0;
    bit           e_clr = 1'b0;
    bit           e_rdy = 1'b0;
    bit           e_ovr = 1'b0;
    bit           e_tmo = 1'b0;
    bit           rdy_next;
    int           e_n = 0;
    int           e_idle = 0;
    logic [W-1:0] e_word = '0;
    logic [W-1:0] e_cmd = '0;

    uart_cmd_ctrl #(
        .NUM_BYTES (NB),
        .TMO_CYCLES(TMO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .clr_rx_rdy (clr_rx_rdy),
        .clr_cmd_rdy(clr_cmd_rdy),
        .cmd        (cmd),
        .cmd_rdy    (cmd_rdy),
        .ovr_err    (ovr_err),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Negedge: compare outputs, then advance the model with the inputs
    // the DUT will sample at the coming posedge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("clr_rx_rdy", clr_rx_rdy, e_clr);
            chk("cmd", cmd, e_cmd);
            chk("cmd_rdy", cmd_rdy, e_rdy);
            chk("ovr_err", ovr_err, e_ovr);
            chk("tmo_err", tmo_err, e_tmo);
            if (clr_rx_rdy === 1'b1 && clr_prev !== 1'b1) clr_rises++;
            if (clr_rx_rdy === 1'b1) clr_hi++;
            if (ovr_err === 1'b1) ovr_cnt++;
            if (tmo_err === 1'b1) tmo_cnt++;
        end
        clr_prev = clr_rx_rdy;
        if (!rst_n) begin
            m_valid = 1'b1;
            e_clr = 0; e_rdy = 0; e_ovr = 0; e_tmo = 0;
            e_n = 0; e_idle = 0; e_word = '0; e_cmd = '0;
        end else if (m_valid) begin
            e_ovr = 0;
            e_tmo = 0;
            rdy_next = e_rdy && !clr_cmd_rdy;
            if (!e_clr) begin
                if (rx_rdy) begin
                    e_word = (e_word << 8) | W'(rx_data);
                    e_n++;
                    e_clr = 1;
                    e_idle = 0;
                end else if (e_n > 0) begin
                    e_idle++;
                    if (TMO_ON && e_idle == TMO) begin
                        e_n = 0; e_word = '0; e_idle = 0; e_tmo = 1;
                    end
                end
            end else if (!rx_rdy) begin
                e_clr = 0;
                if (e_n == NB) begin
                    e_ovr = e_rdy && !clr_cmd_rdy;
                    e_cmd = e_word;
                    rdy_next = 1;
                    e_n = 0;
                end
            end
            e_rdy = rdy_next;
        end
    end

    // Receiver: raise rdy, wait for clr, keep rdy for 'extra' cycles.
    task automatic send_byte(input logic [7:0] b, input int extra,
                             output int t_rise);
        int n;
        @(posedge clk); #1;
        rx_rdy = 1'b1;
        rx_data = b;
        t_rise = cyc;
        n = 0;
        while (clr_rx_rdy !== 1'b1 && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        if (clr_rx_rdy !== 1'b1) begin
            vecs++;
            errs++;
            $display("FAIL ack_wait: clr_rx_rdy=%b, expected 1", clr_rx_rdy);
        end
        repeat (extra) begin
            @(posedge clk); #1;
        end
        rx_rdy = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int r0;
        int n;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_clr_rx_rdy", clr_rx_rdy, 1'b0);
        chk("rst_ovr_err", ovr_err, 1'b0);
        chk("rst_tmo_err", tmo_err, 1'b0);

        r0 = clr_rises;
        send_byte(8'hA5, 1, t0);
        chk("clr_pulses_a5", clr_rises - r0, 1);
        r0 = clr_rises;
        send_byte(8'h3C, 1, t0);
        chk("clr_pulses_3c", clr_rises - r0, 1);
        n = 0;
        while (cmd_rdy !== 1'b1 && n < 10) begin
            idle(1);
            n++;
        end
        chk("cmd_rdy_latency", cyc - t0, 3);
        chk("cmd_a53c", cmd, 16'hA53C);

        r0 = ovr_cnt;
        send_byte(8'h11, 1, t0);
        send_byte(8'h22, 1, t0);
        idle(3);
        chk("cmd_1122", cmd, 16'h1122);
        chk("ovr_rdy_held", cmd_rdy, 1'b1);
        chk("ovr_pulses", ovr_cnt - r0, 1);

        r0 = ovr_cnt;
        send_byte(8'h33, 1, t0);
        send_byte(8'h44, 1, t0);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        chk("set_wins_rdy", cmd_rdy, 1'b1);
        chk("cmd_3344", cmd, 16'h3344);
        idle(2);
        chk("set_wins_no_ovr", ovr_cnt - r0, 0);

        idle(2);
        clr_cmd_rdy = 1'b1;
        idle(1);
        clr_cmd_rdy = 1'b0;
        chk("clr_rdy", cmd_rdy, 1'b0);
        chk("clr_keeps_cmd", cmd, 16'h3344);

        r0 = tmo_cnt;
        send_byte(8'h55, 1, t0);
        idle(105);
`ifdef UART_CMD_BYTE_TIMEOUT_EN
        chk("tmo_pulses", tmo_cnt - r0, 1);
        send_byte(8'h12, 1, t0);
        send_byte(8'h34, 1, t0);
        idle(3);
        chk("cmd_1234", cmd, 16'h1234);
`else
        chk("no_tmo", tmo_cnt - r0, 0);
        send_byte(8'h12, 1, t0);
        send_byte(8'h34, 1, t0);
        idle(3);
        chk("cmd_5512", cmd, 16'h5512);
`endif

        send_byte(8'h99, 1, t0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("mid_rst_cmd", cmd, 16'h0000);
        chk("mid_rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("mid_rst_clr", clr_rx_rdy, 1'b0);
        chk("mid_rst_ovr", ovr_err, 1'b0);
        chk("mid_rst_tmo", tmo_err, 1'b0);
        send_byte(8'hDE, 1, t0);
        send_byte(8'hAD, 1, t0);
        idle(3);
        chk("cmd_dead", cmd, 16'hDEAD);
        chk("dead_rdy", cmd_rdy, 1'b1);

        r0 = clr_hi;
        send_byte(8'h5A, 5, t0);
        idle(2);
        chk("clr_hold_width", clr_hi - r0, 6);
        send_byte(8'hC3, 1, t0);
        idle(3);
        chk("cmd_5ac3", cmd, 16'h5AC3);

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
